// File: rtl/lock_chamber_if.sv
// lock_chamber_if: operator/sensor inputs and door, LED, level and state outputs of the lock chamber controller
interface lock_chamber_if #(parameter int LEVEL_W = 16);
  logic tick;
  logic outer_arrival;
  logic inner_arrival;
  logic outer_door_req;
  logic inner_door_req;
  logic auto_mode;
  logic manual_fill;
  logic manual_drain;
  logic [LEVEL_W-1:0] water_level;
  logic outer_openable;
  logic inner_openable;
  logic outer_door_open;
  logic inner_door_open;
  logic outer_led;
  logic inner_led;
  logic [2:0] state;
  logic reject;
  modport master (
    output tick, outer_arrival, inner_arrival, outer_door_req, inner_door_req,
           auto_mode, manual_fill, manual_drain,
    input  water_level, outer_openable, inner_openable, outer_door_open, inner_door_open,
           outer_led, inner_led, state, reject
  );
  modport slave (
    input  tick, outer_arrival, inner_arrival, outer_door_req, inner_door_req,
           auto_mode, manual_fill, manual_drain,
    output water_level, outer_openable, inner_openable, outer_door_open, inner_door_open,
           outer_led, inner_led, state, reject
  );
endinterface

// File: rtl/lock_chamber_ctrl.sv
// lock_chamber_ctrl: single-chamber gondola lock with two interlocked doors and a tick-driven water level model
module lock_chamber_ctrl #(
  parameter int LEVEL_W     = 16,
  parameter int OUTER_LEVEL = 2800,
  parameter int INNER_LEVEL = 5600,
  parameter int TOLERANCE   = 168,
  parameter int FILL_STEP   = 350,
  parameter int DRAIN_STEP  = 400,
  parameter int ARR_DELAY   = 5,
  parameter int DOOR_TIME   = 3,
  parameter int DEPT_DELAY  = 5,
  parameter int TIMER_W     = 8
) (
  input logic clk,
  input logic reset,
  lock_chamber_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARRIVE, ENTER, EQUALIZE, EXIT} state_t;
  localparam logic [LEVEL_W-1:0] OUT = LEVEL_W'(OUTER_LEVEL);
  localparam logic [LEVEL_W-1:0] INN = LEVEL_W'(INNER_LEVEL);
  localparam logic [LEVEL_W:0] OUT1 = (LEVEL_W+1)'(OUTER_LEVEL);
  localparam logic [LEVEL_W:0] INN1 = (LEVEL_W+1)'(INNER_LEVEL);
  localparam logic [LEVEL_W:0] TOL1 = (LEVEL_W+1)'(TOLERANCE);
  localparam logic [LEVEL_W:0] FILL1 = (LEVEL_W+1)'(FILL_STEP);
  localparam logic [LEVEL_W:0] DRAIN1 = (LEVEL_W+1)'(DRAIN_STEP);
  localparam logic [TIMER_W-1:0] ARR_T = TIMER_W'(ARR_DELAY);
  localparam logic [TIMER_W-1:0] DOOR_T = TIMER_W'(DOOR_TIME);
  localparam logic [TIMER_W-1:0] DEPT_T = TIMER_W'(DEPT_DELAY);
  state_t st;
  logic dir;
  logic [TIMER_W-1:0] timer, tinc;
  logic [LEVEL_W-1:0] level, filled, drained;
  logic [LEVEL_W:0] fill_v, drain_v;
  logic arr_req, dep_req, arr_ok, dep_ok, any_req, go, do_fill, do_drain, frozen;
  assign bus.water_level = level;
  assign bus.state = st;
  assign bus.outer_openable = {1'b0, level} <= OUT1 + TOL1;
  assign bus.inner_openable = {1'b0, level} + TOL1 >= INN1;
  // dir=0: gondola travels outer->inner, dir=1: inner->outer
  always_comb begin
    tinc = &timer ? timer : timer + 1'b1;
    arr_req = dir ? bus.inner_door_req : bus.outer_door_req;
    dep_req = dir ? bus.outer_door_req : bus.inner_door_req;
    arr_ok = dir ? bus.inner_openable : bus.outer_openable;
    dep_ok = dir ? bus.outer_openable : bus.inner_openable;
    any_req = bus.outer_door_req | bus.inner_door_req;
    go = st == IDLE     ? bus.outer_arrival | bus.inner_arrival :
         st == ARRIVE   ? arr_req & (tinc >= ARR_T) & arr_ok :
         st == ENTER    ? tinc >= DOOR_T :
         st == EQUALIZE ? dep_req & dep_ok :
         st == EXIT     ? tinc >= DEPT_T : 1'b1;
    fill_v = {1'b0, level} + FILL1;
    drain_v = {1'b0, level} - DRAIN1;
    filled = fill_v > INN1 ? INN : fill_v[LEVEL_W-1:0];
    drained = {1'b0, level} < OUT1 + DRAIN1 ? OUT : drain_v[LEVEL_W-1:0];
    do_fill = bus.auto_mode ? (st == ARRIVE & dir) | (st == EQUALIZE & ~dir) : bus.manual_fill & ~bus.manual_drain;
    do_drain = bus.auto_mode ? (st == ARRIVE & ~dir) | (st == EQUALIZE & dir) : bus.manual_drain & ~bus.manual_fill;
    frozen = bus.outer_door_open | bus.inner_door_open;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      dir <= 1'b0;
      timer <= '0;
      level <= OUT;
      bus.outer_door_open <= 1'b0;
      bus.inner_door_open <= 1'b0;
      bus.outer_led <= 1'b0;
      bus.inner_led <= 1'b0;
      bus.reject <= 1'b0;
    end else begin
      bus.reject <= bus.tick & any_req & ~go;
      if (bus.tick) begin
        if (!frozen) level <= do_fill ? filled : do_drain ? drained : level;
        timer <= go ? '0 : tinc;
        if (go) begin
          case (st)
            IDLE: begin
              st <= ARRIVE;
              dir <= ~bus.outer_arrival;
              bus.outer_led <= bus.outer_arrival;
              bus.inner_led <= ~bus.outer_arrival;
            end
            ARRIVE: begin
              st <= ENTER;
              bus.outer_door_open <= ~dir;
              bus.inner_door_open <= dir;
              bus.outer_led <= 1'b1;
              bus.inner_led <= 1'b1;
            end
            ENTER: begin
              st <= EQUALIZE;
              bus.outer_door_open <= 1'b0;
              bus.inner_door_open <= 1'b0;
            end
            EQUALIZE: begin
              st <= EXIT;
              bus.outer_door_open <= dir;
              bus.inner_door_open <= ~dir;
              bus.outer_led <= dir;
              bus.inner_led <= ~dir;
            end
            default: begin
              st <= IDLE;
              bus.outer_door_open <= 1'b0;
              bus.inner_door_open <= 1'b0;
              bus.outer_led <= 1'b0;
              bus.inner_led <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// tb_lock_chamber_ctrl: scoreboard bench walking the lock through full cycles, manual level moves and resets
module tb_lock_chamber_ctrl;
  localparam logic [6:0] OA = 7'b1000000, IA = 7'b0100000, ORQ = 7'b0010000, IRQ = 7'b0001000;
  localparam logic [6:0] AU = 7'b0000100, MF = 7'b0000010, MD = 7'b0000001;
  typedef struct {
    logic [2:0] st;
    logic [15:0] lvl;
    logic [1:0] dr;
    logic [1:0] ld;
    logic [1:0] op;
    logic rj;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lock_chamber_if bus ();
  lock_chamber_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] opx(input int l);
    return {l <= 2968, l >= 5432};
  endfunction
  task automatic step(input string tag, input bit rs, input bit tk, input logic [6:0] in,
                      input logic [2:0] st, input int lvl, input logic [1:0] dr, input logic [1:0] ld, input logic rj);
    exp_t e;
    @(negedge clk);
    reset = rs;
    bus.tick = tk;
    {bus.outer_arrival, bus.inner_arrival, bus.outer_door_req, bus.inner_door_req,
     bus.auto_mode, bus.manual_fill, bus.manual_drain} = in;
    e.st = st;
    e.lvl = lvl[15:0];
    e.dr = dr;
    e.ld = ld;
    e.op = opx(lvl);
    e.rj = rj;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".state"}, 32'(bus.state), 32'(e.st));
    chk({tag, ".level"}, 32'(bus.water_level), 32'(e.lvl));
    chk({tag, ".doors"}, 32'({bus.outer_door_open, bus.inner_door_open}), 32'(e.dr));
    chk({tag, ".leds"}, 32'({bus.outer_led, bus.inner_led}), 32'(e.ld));
    chk({tag, ".openable"}, 32'({bus.outer_openable, bus.inner_openable}), 32'(e.op));
    chk({tag, ".reject"}, 32'(bus.reject), 32'(e.rj));
  endtask
  initial begin
    bus.tick = 1'b0;
    {bus.outer_arrival, bus.inner_arrival, bus.outer_door_req, bus.inner_door_req,
     bus.auto_mode, bus.manual_fill, bus.manual_drain} = '0;
    repeat (2) @(posedge clk);
    step("rst", 1, 0, AU, 0, 2800, 2'b00, 2'b00, 0);
    step("t1_arrive", 0, 1, AU | OA, 1, 2800, 2'b00, 2'b10, 0);
    step("t2_a1", 0, 1, AU, 1, 2800, 2'b00, 2'b10, 0);
    step("t2_a2", 0, 1, AU, 1, 2800, 2'b00, 2'b10, 0);
    step("t2_early", 0, 1, AU | ORQ, 1, 2800, 2'b00, 2'b10, 1);
    step("t2_pulse", 0, 0, AU, 1, 2800, 2'b00, 2'b10, 0);
    step("t2_wrong", 0, 1, AU | IRQ, 1, 2800, 2'b00, 2'b10, 1);
    step("t2_enter", 0, 1, AU | ORQ, 2, 2800, 2'b10, 2'b11, 0);
    step("t3_e1", 0, 1, AU, 2, 2800, 2'b10, 2'b11, 0);
    step("t3_e2", 0, 1, AU, 2, 2800, 2'b10, 2'b11, 0);
    step("t3_eq", 0, 1, AU, 3, 2800, 2'b00, 2'b11, 0);
    for (int k = 1; k <= 6; k++) step("t3_fill", 0, 1, AU, 3, 2800 + 350 * k, 2'b00, 2'b11, 0);
    step("t3_notyet", 0, 1, AU | IRQ, 3, 5250, 2'b00, 2'b11, 1);
    step("t3_fill8", 0, 1, AU, 3, 5600, 2'b00, 2'b11, 0);
    step("t3_exit", 0, 1, AU | IRQ, 4, 5600, 2'b01, 2'b01, 0);
    step("t3_frozen", 0, 1, MD, 4, 5600, 2'b01, 2'b01, 0);
    for (int k = 0; k < 3; k++) step("t3_x", 0, 1, AU, 4, 5600, 2'b01, 2'b01, 0);
    step("t3_idle", 0, 1, AU, 0, 5600, 2'b00, 2'b00, 0);
    step("t4_arrive", 0, 1, IA, 1, 5600, 2'b00, 2'b01, 0);
    for (int k = 1; k <= 7; k++) step("t4_drain", 0, 1, MD, 1, 5600 - 400 * k, 2'b00, 2'b01, 0);
    step("t4_dclamp", 0, 1, MD, 1, 2800, 2'b00, 2'b01, 0);
    step("t4_both", 0, 1, MF | MD, 1, 2800, 2'b00, 2'b01, 0);
    step("t4_fill", 0, 1, MF, 1, 3150, 2'b00, 2'b01, 0);
    step("t4_dsat", 0, 1, MD, 1, 2800, 2'b00, 2'b01, 0);
    step("t4_notopen", 0, 1, IRQ, 1, 2800, 2'b00, 2'b01, 1);
    step("t4_arrign", 0, 1, OA, 1, 2800, 2'b00, 2'b01, 0);
    for (int k = 1; k <= 8; k++) step("t4_mfill", 0, 1, MF, 1, 2800 + 350 * k, 2'b00, 2'b01, 0);
    step("t4_md", 0, 1, MD, 1, 5200, 2'b00, 2'b01, 0);
    step("t4_mf1", 0, 1, MF, 1, 5550, 2'b00, 2'b01, 0);
    step("t4_fsat", 0, 1, MF, 1, 5600, 2'b00, 2'b01, 0);
    step("t4_enter", 0, 1, IRQ, 2, 5600, 2'b01, 2'b11, 0);
    step("t5_rst", 1, 1, AU, 0, 2800, 2'b00, 2'b00, 0);
    step("t5_both", 0, 1, AU | OA | IA, 1, 2800, 2'b00, 2'b10, 0);
    step("t5_dir", 0, 1, AU | IRQ, 1, 2800, 2'b00, 2'b10, 1);
    for (int k = 0; k < 3; k++) step("t6_a", 0, 1, AU, 1, 2800, 2'b00, 2'b10, 0);
    step("t6_enter", 0, 1, AU | ORQ, 2, 2800, 2'b10, 2'b11, 0);
    for (int k = 0; k < 2; k++) step("t6_e", 0, 1, AU, 2, 2800, 2'b10, 2'b11, 0);
    step("t6_eq", 0, 1, AU, 3, 2800, 2'b00, 2'b11, 0);
    for (int k = 1; k <= 8; k++) step("t6_fill", 0, 1, AU, 3, 2800 + 350 * k, 2'b00, 2'b11, 0);
    step("t6_exit", 0, 1, AU | IRQ, 4, 5600, 2'b01, 2'b01, 0);
    step("t6_x", 0, 1, AU, 4, 5600, 2'b01, 2'b01, 0);
    step("t6_rst", 1, 1, AU | OA, 0, 2800, 2'b00, 2'b00, 0);
    step("t6_freeze", 0, 0, OA | MF, 0, 2800, 2'b00, 2'b00, 0);
    step("t6_freeze2", 0, 0, IA | MF | ORQ, 0, 2800, 2'b00, 2'b00, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
